// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential PC fetch into a DEPTH-entry {instr, pc} queue with branch redirect and squash
module instr_fetch_queue #(
    parameter int ADDR_W = 64,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int COND_W = 19,
    parameter int UNCOND_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic              uncond_br,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [COND_W-1:0] cond_off,
    input  logic [UNCOND_W-1:0] br_off,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_W-1:0] pc_q, issued_pc_q, off, target;
    logic              inflight, push, pop;
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [31:0]       q_instr [DEPTH];
    logic [ADDR_W-1:0] q_pc [DEPTH];
    // the in-flight fetch is counted so its return always finds a free slot
    always_comb begin
        off = uncond_br ? ADDR_W'($signed(br_off)) : ADDR_W'($signed(cond_off));
        target = br_pc + (off << 2);
        imem_req = !rst && !redirect && (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
        imem_addr = pc_q;
        out_valid = !rst && !redirect && (count != '0);
        out_instr = q_instr[rd_ptr];
        out_pc = q_pc[rd_ptr];
        push = inflight && !redirect;
        pop = out_valid && out_ready;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight <= 1'b0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            pc_q <= target;
            inflight <= 1'b0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (imem_req) begin
                pc_q <= pc_q + ADDR_W'(4);
                issued_pc_q <= pc_q;
            end
            inflight <= imem_req;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr] <= issued_pc_q;
        end
    end
endmodule
